// File: rtl/rpn_stack_calc.sv
// Pushbutton-driven RPN stack calculator: debounced-edge key presses select
// stack and ALU operations from one of four banks chosen by mode.
module rpn_stack_calc #(
  parameter int W     = 16,
  parameter int DEPTH = 8,
  parameter int CW    = 8
) (
  input  logic                           clk2,
  input  logic                           rst,
  input  logic [1:0]                     mode,
  input  logic [3:0]                     key,
  input  logic [W-1:0]                   val,
  output logic [W-1:0]                   top,
  output logic [W-1:0]                   next,
  output logic [CW-1:0]                  counter,
  output logic [$clog2(DEPTH+1)-1:0]     depth,
  output logic                           ovf,
  output logic                           unf
);

  localparam int DW = $clog2(DEPTH+1);
  localparam logic [DW-1:0] FULL = DW'(DEPTH);

  logic [3:0]          key_s_q, key_s_d, key_p_q, key_p_d;
  logic [3:0]          press;
  logic [1:0]          sel;
  logic signed [W-1:0] stk_q [DEPTH];
  logic signed [W-1:0] stk_d [DEPTH];
  logic signed [W-1:0] pushed [DEPTH];
  logic signed [W-1:0] popped [DEPTH];
  logic [DW-1:0]       depth_q, depth_d;
  logic [CW-1:0]       counter_q, counter_d;
  logic                ovf_q, ovf_d, unf_q, unf_d;
  logic                accept;

  function automatic logic signed [W-1:0] alu_bin(input logic [1:0] m, input logic [1:0] k,
                                                  input logic signed [W-1:0] nx,
                                                  input logic signed [W-1:0] tp);
    logic signed [W-1:0] r;
    r = '0;
    case ({m, k})
      4'b0100: r = nx + tp;
      4'b0101: r = nx - tp;
      4'b0110: r = nx * tp;
      4'b1000: r = nx & tp;
      4'b1001: r = nx | tp;
      4'b1010: r = nx ^ tp;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic signed [W-1:0] alu_un(input logic [1:0] m, input logic signed [W-1:0] tp);
    return (m == 2'b01) ? -tp : ~tp;
  endfunction

  // Shifted stack images; slots at or beyond depth are always zero
  always_comb begin
    pushed[0] = '0;
    for (int i = 1; i < DEPTH; i++) pushed[i] = stk_q[i-1];
    for (int i = 0; i < DEPTH-1; i++) popped[i] = stk_q[i+1];
    popped[DEPTH-1] = '0;
  end

  always_comb begin
    press = key_p_q & ~key_s_q;
    if (press[0])      sel = 2'd0;
    else if (press[1]) sel = 2'd1;
    else if (press[2]) sel = 2'd2;
    else               sel = 2'd3;
  end

  always_comb begin
    key_s_d   = key;
    key_p_d   = key_s_q;
    stk_d     = stk_q;
    depth_d   = depth_q;
    counter_d = counter_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    accept    = 1'b0;
    if (|press) begin
      case ({mode, sel})
        4'b0000, 4'b0010, 4'b1101: begin
          // push / dup / over share the push path, differing only in source
          if ((sel == 2'd2 && depth_q == '0) || (sel == 2'd1 && depth_q < DW'(2))) begin
            unf_d = 1'b1;
          end else if (depth_q == FULL) begin
            ovf_d = 1'b1;
          end else begin
            stk_d = pushed;
            if (sel == 2'd0)      stk_d[0] = val;
            else if (sel == 2'd2) stk_d[0] = stk_q[0];
            else                  stk_d[0] = stk_q[1];
            depth_d = depth_q + DW'(1);
            accept  = 1'b1;
          end
        end
        4'b0001: begin
          if (depth_q == '0) unf_d = 1'b1;
          else begin
            stk_d   = popped;
            depth_d = depth_q - DW'(1);
            accept  = 1'b1;
          end
        end
        4'b0011: begin
          for (int i = 0; i < DEPTH; i++) stk_d[i] = '0;
          depth_d = '0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          accept  = 1'b1;
        end
        4'b0100, 4'b0101, 4'b0110, 4'b1000, 4'b1001, 4'b1010: begin
          if (depth_q < DW'(2)) unf_d = 1'b1;
          else begin
            stk_d    = popped;
            stk_d[0] = alu_bin(mode, sel, stk_q[1], stk_q[0]);
            depth_d  = depth_q - DW'(1);
            accept   = 1'b1;
          end
        end
        4'b0111, 4'b1011: begin
          if (depth_q == '0) unf_d = 1'b1;
          else begin
            stk_d[0] = alu_un(mode, stk_q[0]);
            accept   = 1'b1;
          end
        end
        4'b1100: begin
          if (depth_q < DW'(2)) unf_d = 1'b1;
          else begin
            stk_d[0] = stk_q[1];
            stk_d[1] = stk_q[0];
            accept   = 1'b1;
          end
        end
        default: accept = 1'b0;
      endcase
    end
    if (accept) counter_d = counter_q + CW'(1);
  end

  always_ff @(posedge clk2) begin
    if (!rst) begin
      key_s_q   <= 4'hF;
      key_p_q   <= 4'hF;
      stk_q     <= '{default: '0};
      depth_q   <= '0;
      counter_q <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      key_s_q   <= key_s_d;
      key_p_q   <= key_p_d;
      stk_q     <= stk_d;
      depth_q   <= depth_d;
      counter_q <= counter_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  assign top     = stk_q[0];
  assign next    = stk_q[1];
  assign depth   = depth_q;
  assign counter = counter_q;
  assign ovf     = ovf_q;
  assign unf     = unf_q;

endmodule

// File: tb/tb_rpn_stack_calc.sv
// Directed bench for rpn_stack_calc with hand-computed expected stack state.
module tb_rpn_stack_calc;
  logic        clk2 = 1'b0;
  logic        rst  = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [3:0]  key  = 4'hF;
  logic [15:0] val  = 16'h0;
  logic [15:0] top, next;
  logic [7:0]  counter;
  logic [3:0]  depth;
  logic        ovf, unf;
  int          errors = 0;
  int          checks = 0;

  rpn_stack_calc #(.W(16), .DEPTH(8), .CW(8)) dut (
    .clk2(clk2), .rst(rst), .mode(mode), .key(key), .val(val),
    .top(top), .next(next), .counter(counter), .depth(depth), .ovf(ovf), .unf(unf)
  );

  always #5 clk2 = ~clk2;

  task automatic tick();
    @(posedge clk2);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Press one key, hold two edges so it executes, then release for two edges
  task automatic do_op(input logic [1:0] m, input int idx, input logic [15:0] v);
    logic [3:0] k;
    k = 4'hF;
    k[idx] = 1'b0;
    mode = m;
    val  = v;
    key  = k;
    tick(); tick();
    key = 4'hF;
    tick(); tick();
  endtask

  initial begin
    tick(); tick();
    rst = 1'b1;
    tick();
    check("rst_top", 32'(top), 32'h0);
    check("rst_next", 32'(next), 32'h0);
    check("rst_depth", 32'(depth), 32'h0);
    check("rst_counter", 32'(counter), 32'h0);
    check("rst_ovf", 32'(ovf), 32'h0);
    check("rst_unf", 32'(unf), 32'h0);

    do_op(2'b00, 0, 16'h0005);
    do_op(2'b00, 0, 16'h0003);
    check("push_top", 32'(top), 32'h3);
    check("push_next", 32'(next), 32'h5);
    check("push_depth", 32'(depth), 32'h2);
    check("push_counter", 32'(counter), 32'h2);

    do_op(2'b01, 1, 16'h0000);
    check("sub_top", 32'(top), 32'h2);
    check("sub_next", 32'(next), 32'h0);
    check("sub_depth", 32'(depth), 32'h1);
    check("sub_counter", 32'(counter), 32'h3);
    do_op(2'b01, 3, 16'h0000);
    check("neg_top", 32'(top), 32'hFFFE);
    check("neg_depth", 32'(depth), 32'h1);

    do_op(2'b00, 0, 16'hFFFF);
    do_op(2'b00, 0, 16'h0002);
    do_op(2'b01, 0, 16'h0000);
    check("add_top", 32'(top), 32'h1);
    check("add_next", 32'(next), 32'hFFFE);
    check("add_counter", 32'(counter), 32'h7);
    do_op(2'b00, 0, 16'h8000);
    do_op(2'b00, 0, 16'h0002);
    do_op(2'b01, 2, 16'h0000);
    check("mul_top", 32'(top), 32'h0);
    check("mul_next", 32'(next), 32'h1);
    check("mul_depth", 32'(depth), 32'h3);
    check("mul_counter", 32'(counter), 32'hA);

    do_op(2'b00, 3, 16'h0000);
    check("clr1_depth", 32'(depth), 32'h0);
    check("clr1_counter", 32'(counter), 32'hB);

    for (int i = 0; i < 9; i++) do_op(2'b00, 0, 16'(16'h0010 + i));
    check("full_depth", 32'(depth), 32'h8);
    check("full_ovf", 32'(ovf), 32'h1);
    check("full_counter", 32'(counter), 32'h13);
    check("full_top", 32'(top), 32'h17);
    check("full_next", 32'(next), 32'h16);
    do_op(2'b00, 3, 16'h0000);
    check("clr2_depth", 32'(depth), 32'h0);
    check("clr2_ovf", 32'(ovf), 32'h0);
    check("clr2_top", 32'(top), 32'h0);
    check("clr2_next", 32'(next), 32'h0);
    check("clr2_counter", 32'(counter), 32'h14);

    do_op(2'b00, 0, 16'h0F0F);
    do_op(2'b00, 0, 16'h00FF);
    do_op(2'b10, 0, 16'h0000);
    check("and_top", 32'(top), 32'h000F);
    check("and_depth", 32'(depth), 32'h1);
    do_op(2'b00, 0, 16'h00F0);
    do_op(2'b10, 1, 16'h0000);
    check("or_top", 32'(top), 32'h00FF);
    do_op(2'b00, 0, 16'h0F0F);
    do_op(2'b10, 2, 16'h0000);
    check("xor_top", 32'(top), 32'h0FF0);
    do_op(2'b10, 3, 16'h0000);
    check("not_top", 32'(top), 32'hF00F);
    check("not_counter", 32'(counter), 32'h1C);
    do_op(2'b00, 0, 16'h1234);
    do_op(2'b11, 0, 16'h0000);
    check("swap_top", 32'(top), 32'hF00F);
    check("swap_next", 32'(next), 32'h1234);
    do_op(2'b11, 1, 16'h0000);
    check("over_top", 32'(top), 32'h1234);
    check("over_next", 32'(next), 32'hF00F);
    check("over_depth", 32'(depth), 32'h3);
    do_op(2'b11, 2, 16'h0000);
    check("nop_counter", 32'(counter), 32'h1F);
    do_op(2'b00, 2, 16'h0000);
    check("dup_top", 32'(top), 32'h1234);
    check("dup_next", 32'(next), 32'h1234);
    check("dup_depth", 32'(depth), 32'h4);
    do_op(2'b00, 1, 16'h0000);
    check("pop_next", 32'(next), 32'hF00F);
    check("pop_depth", 32'(depth), 32'h3);
    do_op(2'b01, 3, 16'h0000);
    check("neg2_top", 32'(top), 32'hEDCC);
    check("neg2_counter", 32'(counter), 32'h22);

    do_op(2'b00, 3, 16'h0000);
    do_op(2'b01, 0, 16'h0000);
    check("unf_flag", 32'(unf), 32'h1);
    check("unf_depth", 32'(depth), 32'h0);
    check("unf_counter", 32'(counter), 32'h23);

    mode = 2'b00;
    val  = 16'h0042;
    key  = 4'b1110;
    for (int i = 0; i < 10; i++) tick();
    key = 4'hF;
    tick(); tick();
    check("hold_depth", 32'(depth), 32'h1);
    check("hold_top", 32'(top), 32'h42);
    check("hold_counter", 32'(counter), 32'h24);
    check("hold_unf_sticky", 32'(unf), 32'h1);

    val = 16'h0077;
    key = 4'b1100;
    tick(); tick();
    check("multi_depth", 32'(depth), 32'h2);
    check("multi_top", 32'(top), 32'h77);
    check("multi_next", 32'(next), 32'h42);
    check("multi_counter", 32'(counter), 32'h25);
    rst = 1'b0;
    tick();
    check("mid_rst_top", 32'(top), 32'h0);
    check("mid_rst_next", 32'(next), 32'h0);
    check("mid_rst_depth", 32'(depth), 32'h0);
    check("mid_rst_counter", 32'(counter), 32'h0);
    check("mid_rst_ovf", 32'(ovf), 32'h0);
    check("mid_rst_unf", 32'(unf), 32'h0);
    rst = 1'b1;
    tick();
    check("rel_edge1_depth", 32'(depth), 32'h0);
    tick();
    check("rel_depth", 32'(depth), 32'h1);
    check("rel_top", 32'(top), 32'h77);
    check("rel_counter", 32'(counter), 32'h1);
    tick(); tick();
    check("rel_norepeat", 32'(counter), 32'h1);
    key = 4'hF;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
